custom_acc_en_sequencer: RTL and testbench

//  Generates per-channel accumulator enables for the Custom systolic datapath: NUM_CH skewed, runtime-length windows.

---
 rtl/custom_acc_pkg.sv | 28 ++
 rtl/custom_acc_win_cmp.sv | 30 +++
 rtl/custom_acc_en_sequencer.sv | 104 ++++++++++
 tb/tb_custom_acc_en_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/custom_acc_pkg.sv
// Shared types and elaboration helpers for the Custom accumulator-enable sequencer.
package custom_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_LEAD   = 5;
  localparam int DEF_SKEW   = 1;
  localparam int DEF_LEN_W  = 5;
  localparam int DEF_CNT_W  = 6;

  function automatic int win_start(input int c, input int lead, input int skew);
    return lead + c * skew;
  endfunction

  // The counter runs one past the last enabled stage before leaving RUN, so that value must fit.
  function automatic bit cnt_fits(input int num_ch, input int lead, input int skew,
                                  input int len_w, input int cnt_w);
    return (lead + (num_ch - 1) * skew + (1 << len_w) - 1) < (1 << cnt_w);
  endfunction

  localparam bit DEF_CNT_W_OK = cnt_fits(DEF_NUM_CH, DEF_LEAD, DEF_SKEW, DEF_LEN_W, DEF_CNT_W);

endpackage

// File: rtl/custom_acc_win_cmp.sv
// One channel's window comparator: enable while start <= cnt < start+len.
// Optional first-cycle clear output under CUSTOM_ACC_CLR_EN.
module custom_acc_win_cmp #(
  parameter int CNT_W = 6,
  parameter int LEN_W = 5
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W:0]   i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_run_ok,
  output logic             o_en
`ifdef CUSTOM_ACC_CLR_EN
  ,
  output logic             o_clr
`endif
);

  logic [CNT_W:0] w_cnt;
  logic [CNT_W:0] w_stop;

  assign w_cnt  = {1'b0, i_cnt};
  assign w_stop = i_start + {{(CNT_W + 1 - LEN_W){1'b0}}, i_len};
  assign o_en   = i_run_ok && (w_cnt >= i_start) && (w_cnt < w_stop);

`ifdef CUSTOM_ACC_CLR_EN
  assign o_clr  = o_en && (w_cnt == i_start);
`else
`endif

endmodule

// File: rtl/custom_acc_en_sequencer.sv
// Skewed per-channel accumulator enable sequencer with start/busy/done handshake and stall.
// Optional per-channel first-cycle clear output when CUSTOM_ACC_CLR_EN is defined.
module custom_acc_en_sequencer
  import custom_acc_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int LEAD   = DEF_LEAD,
  parameter int SKEW   = DEF_SKEW,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [NUM_CH-1:0] acc_en_o
`ifdef CUSTOM_ACC_CLR_EN
  ,
  output logic [NUM_CH-1:0] acc_clr_o
`endif
);

  if (!cnt_fits(NUM_CH, LEAD, SKEW, LEN_W, CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too small for LEAD+(NUM_CH-1)*SKEW+2^LEN_W-1");
  end

  localparam logic [CNT_W:0] END_BASE = (CNT_W + 1)'(LEAD + (NUM_CH - 1) * SKEW - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W:0]   w_end;
  logic             w_last;
  logic             w_run_ok;

  assign w_end    = END_BASE + {{(CNT_W + 1 - LEN_W){1'b0}}, r_len};
  assign w_last   = ({1'b0, r_cnt} == w_end);
  assign w_run_ok = (r_state == RUN) && !stall_i;
  assign cnt_o    = r_cnt;

  always_comb begin
    w_next = r_state;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) w_next = (len_i != '0) ? RUN : DONE;
      end
      RUN: begin
        busy_o = 1'b1;
        if (!stall_i && w_last) w_next = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start_i && len_i != '0) begin
        r_cnt <= '0;
        r_len <= len_i;
      end else if (r_state == RUN && !stall_i) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [CNT_W:0] S_C = (CNT_W + 1)'(win_start(c, LEAD, SKEW));
`ifdef CUSTOM_ACC_CLR_EN
    custom_acc_win_cmp #(.CNT_W(CNT_W), .LEN_W(LEN_W)) u_cmp (
      .i_cnt   (r_cnt),
      .i_start (S_C),
      .i_len   (r_len),
      .i_run_ok(w_run_ok),
      .o_en    (acc_en_o[c]),
      .o_clr   (acc_clr_o[c])
    );
`else
    custom_acc_win_cmp #(.CNT_W(CNT_W), .LEN_W(LEN_W)) u_cmp (
      .i_cnt   (r_cnt),
      .i_start (S_C),
      .i_len   (r_len),
      .i_run_ok(w_run_ok),
      .o_en    (acc_en_o[c])
    );
`endif
  end

endmodule

// File: tb/tb_custom_acc_en_sequencer.sv
// Scoreboard bench for custom_acc_en_sequencer: the stimulus side predicts every cycle of a run,
// a negedge monitor pops and compares. acc_clr_o is checked when CUSTOM_ACC_CLR_EN is defined.
module tb_custom_acc_en_sequencer;

  localparam int NUM_CH = 4;
  localparam int LEAD   = 5;
  localparam int SKEW   = 1;
  localparam int LEN_W  = 5;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic              stall_i;
  logic              busy_o;
  logic              done_o;
  logic [CNT_W-1:0]  cnt_o;
  logic [NUM_CH-1:0] acc_en_o;
`ifdef CUSTOM_ACC_CLR_EN
  logic [NUM_CH-1:0] acc_clr_o;
`endif

  always #5 clk = ~clk;

  custom_acc_en_sequencer #(
    .NUM_CH(NUM_CH), .LEAD(LEAD), .SKEW(SKEW), .LEN_W(LEN_W), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .len_i    (len_i),
    .stall_i  (stall_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .cnt_o    (cnt_o),
    .acc_en_o (acc_en_o)
`ifdef CUSTOM_ACC_CLR_EN
    ,
    .acc_clr_o(acc_clr_o)
`endif
  );

  typedef struct {
    bit                busy;
    bit                done;
    bit                cntCare;
    int                cnt;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] clr;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  bit   monOn  = 1'b0;

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected record per cycle while a run is predicted, otherwise the DUT must be idle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (monOn) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("busy", int'(busy_o), int'(e.busy));
        checkOutput("done", int'(done_o), int'(e.done));
        checkOutput("acc_en", int'(acc_en_o), int'(e.en));
        if (e.cntCare) checkOutput("cnt", int'(cnt_o), e.cnt);
`ifdef CUSTOM_ACC_CLR_EN
        checkOutput("acc_clr", int'(acc_clr_o), int'(e.clr));
`endif
      end else begin
        checkOutput("idle_busy", int'(busy_o), 0);
        checkOutput("idle_done", int'(done_o), 0);
        checkOutput("idle_en", int'(acc_en_o), 0);
`ifdef CUSTOM_ACC_CLR_EN
        checkOutput("idle_clr", int'(acc_clr_o), 0);
`endif
      end
    end
  end

  // One run from IDLE. The model counts effective (unstalled) stages k; channel c is enabled on
  // an unstalled cycle iff LEAD+c*SKEW <= k < LEAD+c*SKEW+len, and the run ends after stage
  // LEAD+(NUM_CH-1)*SKEW+len-1 is processed. forceAt/forceLen inject a directed stall burst,
  // abortAt asserts reset on the cycle with that stage count.
  task automatic applyStimulus(input int len, input int stallPct, input int forceAt,
                               input int forceLen, input int abortAt, input bit noise);
    exp_t e;
    int   k;
    int   forced;
    int   lastStage;
    int   sc;
    bit   s;
    bit   f;

    start_i = 1'b1;
    len_i   = LEN_W'(len);
    stall_i = 1'($urandom_range(1));
    tick();
    start_i = noise ? 1'($urandom_range(1)) : 1'b0;

    if (len == 0) begin
      e.busy = 1'b0; e.done = 1'b1; e.cntCare = 1'b0; e.cnt = 0; e.en = '0; e.clr = '0;
      expQ.push_back(e);
      stall_i = 1'($urandom_range(1));
      tick();
      start_i = 1'b0;
      return;
    end

    lastStage = LEAD + (NUM_CH - 1) * SKEW + len - 1;
    k = 0;
    forced = 0;
    forever begin
      f = (k == forceAt) && (forced < forceLen);
      if (f) forced++;
      s = f || (int'($urandom_range(99)) < stallPct);
      stall_i = s;
      if (noise) begin
        start_i = 1'($urandom_range(1));
        len_i   = LEN_W'($urandom);
      end
      e.busy = 1'b1; e.done = 1'b0; e.cntCare = 1'b1; e.cnt = k;
      e.en = '0; e.clr = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sc = LEAD + c * SKEW;
        e.en[c]  = !s && (k >= sc) && (k < sc + len);
        e.clr[c] = e.en[c] && (k == sc);
      end
      expQ.push_back(e);
      if (k == abortAt) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_i = 1'b0;
        stall_i = 1'b0;
        return;
      end
      tick();
      if (!s) begin
        if (k == lastStage) break;
        k++;
      end
    end

    e.busy = 1'b0; e.done = 1'b1; e.cntCare = 1'b1; e.cnt = lastStage + 1;
    e.en = '0; e.clr = '0;
    expQ.push_back(e);
    stall_i = 1'($urandom_range(1));
    if (noise) start_i = 1'($urandom_range(1));
    tick();
    start_i = 1'b0;
    stall_i = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b1;
    len_i   = LEN_W'(5);
    stall_i = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy", int'(busy_o), 0);
    checkOutput("rst_done", int'(done_o), 0);
    checkOutput("rst_cnt", int'(cnt_o), 0);
    checkOutput("rst_en", int'(acc_en_o), 0);
`ifdef CUSTOM_ACC_CLR_EN
    checkOutput("rst_clr", int'(acc_clr_o), 0);
`endif
    rst     = 1'b0;
    start_i = 1'b0;
    tick();
    checkOutput("rst_start_ignored", int'(busy_o), 0);
    monOn = 1'b1;

    applyStimulus(4, 0, -1, 0, -1, 1'b0);
    applyStimulus(4, 0, 6, 3, -1, 1'b0);
    applyStimulus(0, 0, -1, 0, -1, 1'b0);
    tick();
    applyStimulus(4, 0, -1, 0, 7, 1'b1);
    applyStimulus(2, 0, -1, 0, -1, 1'b0);
    applyStimulus(31, 0, -1, 0, -1, 1'b0);
    applyStimulus(4, 0, 5, 1, -1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(($urandom_range(9) == 0) ? 0 : int'($urandom_range(31, 1)),
                    int'($urandom_range(40)), -1, 0, -1, 1'b1);
      for (int g = 0; g < int'($urandom_range(2)); g++) begin
        stall_i = 1'($urandom_range(1));
        tick();
      end
    end

    tick();
    tick();
    checkOutput("queue_drained", expQ.size(), 0);
    monOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
